square_motion_ctrl: RTL and testbench

//  Frame-synchronous motion controller for the two-square test pattern. Debounces the
//  raw move pushbutton across frames and steps the square pair once per frame on VS.

---
 rtl/square_motion_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_square_motion_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/square_motion_ctrl.sv
// -----------------------------------------------------------------------------
// square_motion_ctrl
//   Frame-synchronous motion controller for the two-square test pattern.
//   The raw move key is debounced across frames, and the square pair steps
//   once per frame tick (falling edge of the synchronised VS). At the screen
//   edge the pair either wraps home or bounces. The four horizontal bounds
//   only change right after a frame tick, so they are stable for a whole frame.
//
// Ports
//   CLK       in   1   pixel clock
//   rst       in   1   asynchronous, active-low reset
//   VS        in   1   vertical sync, active-low (frame tick on 1->0)
//   KEY_MOVE  in   1   raw move pushbutton, active-low, asynchronous
//   MODE      in   1   0 = wrap to START_X at edge, 1 = bounce
//   SPEED     in   3   pixels per frame, 0 treated as 1
//   LEFT_L    out  11  left square left bound   (= x)
//   LEFT_R    out  11  left square right bound  (= x+SQ_W)
//   RIGHT_L   out  11  right square left bound  (= x+SQ_W+SQ_GAP)
//   RIGHT_R   out  11  right square right bound (= x+SPAN)
//   MOVING    out  1   high while in RUN or REL
//   DIR       out  1   0 = moving right, 1 = moving left
//   FRAME     out  1   one-CLK pulse per detected frame tick
// -----------------------------------------------------------------------------
module square_motion_ctrl #(
  parameter int H_VISIBLE  = 640,
  parameter int SQ_W       = 64,
  parameter int SQ_GAP     = 64,
  parameter int START_X    = 0,
  parameter int DEB_FRAMES = 3
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        VS,
  input  logic        KEY_MOVE,
  input  logic        MODE,
  input  logic [2:0]  SPEED,
  output logic [10:0] LEFT_L,
  output logic [10:0] LEFT_R,
  output logic [10:0] RIGHT_L,
  output logic [10:0] RIGHT_R,
  output logic        MOVING,
  output logic        DIR,
  output logic        FRAME
);

  localparam int SPAN = 2 * SQ_W + SQ_GAP;
  localparam logic [10:0] X_MAX   = 11'(H_VISIBLE - SPAN);
  localparam logic [10:0] HOME_X  = 11'(START_X);
  localparam logic [10:0] W_SQ    = 11'(SQ_W);
  localparam logic [10:0] W_RL    = 11'(SQ_W + SQ_GAP);
  localparam logic [10:0] W_SPAN  = 11'(SPAN);
  localparam int          CW      = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, REL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          vs_s1, vs_s2, vs_d;
  logic          key_s1, key_s2;
  logic [10:0]   step;
  logic [10:0]   step_x;
  logic          step_dir;
  logic          step_en;

  // Two-flop synchronisers for the asynchronous inputs, then a falling-edge
  // detector on the synchronised VS. FRAME rises 3 CLKs after the VS pin falls.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      vs_s1  <= 1'b1;
      vs_s2  <= 1'b1;
      vs_d   <= 1'b1;
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      FRAME  <= 1'b0;
    end else begin
      vs_s1  <= VS;
      vs_s2  <= vs_s1;
      vs_d   <= vs_s2;
      key_s1 <= KEY_MOVE;
      key_s2 <= key_s1;
      FRAME  <= vs_d & ~vs_s2;
    end
  end

  // Next position/direction for one step. LEFT_L is the position register x.
  // NOTE: every variable gets a default first so this stays purely
  // combinational and no latch is inferred on the untaken branches.
  always_comb begin
    step     = (SPEED == 3'd0) ? 11'd1 : {8'd0, SPEED};
    step_x   = LEFT_L;
    step_dir = DIR;
    if (!DIR) begin
      if (LEFT_L + step > X_MAX) begin
        if (MODE) begin
          step_x   = X_MAX;
          step_dir = 1'b1;
        end else begin
          step_x   = HOME_X;
        end
      end else begin
        step_x = LEFT_L + step;
      end
    end else if (!MODE) begin
      // Leftward travel left over from bounce mode: turn round, hold position.
      step_dir = 1'b0;
    end else if (LEFT_L < step) begin
      step_x   = 11'd0;
      step_dir = 1'b0;
    end else begin
      step_x = LEFT_L - step;
    end
  end

  assign step_en = FRAME && (state == RUN || state == REL);

  // Debounce FSM: advances only on frame ticks, MOVING registered alongside.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      MOVING <= 1'b0;
    end else if (FRAME) begin
      case (state)
        IDLE: if (!key_s2) begin
          if (DEB_FRAMES == 1) begin
            state  <= RUN;
            MOVING <= 1'b1;
          end else begin
            state <= ARM;
            cnt   <= CW'(1);
          end
        end
        ARM: if (key_s2) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt >= CNT_LAST) begin
          state  <= RUN;
          cnt    <= '0;
          MOVING <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        RUN: if (key_s2) begin
          state <= REL;
          cnt   <= CW'(1);
        end
        REL: if (!key_s2) begin
          state <= RUN;
          cnt   <= '0;
        end else if (cnt >= CNT_LAST) begin
          state  <= IDLE;
          cnt    <= '0;
          MOVING <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          MOVING <= 1'b0;
        end
      endcase
    end
  end

  // Bounds are registered together so all four change on the same edge.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      LEFT_L  <= HOME_X;
      LEFT_R  <= HOME_X + W_SQ;
      RIGHT_L <= HOME_X + W_RL;
      RIGHT_R <= HOME_X + W_SPAN;
      DIR     <= 1'b0;
    end else if (step_en) begin
      LEFT_L  <= step_x;
      LEFT_R  <= step_x + W_SQ;
      RIGHT_L <= step_x + W_RL;
      RIGHT_R <= step_x + W_SPAN;
      DIR     <= step_dir;
    end
  end

endmodule

// File: tb/tb_square_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_square_motion_ctrl
//   Directed bench: a per-frame vector table for debounce/step behaviour,
//   followed by hand-written sequences for edge wrap/bounce, FRAME latency,
//   mid-frame input changes, missing VS and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_square_motion_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic        VS;
  logic        KEY_MOVE;
  logic        MODE;
  logic [2:0]  SPEED;
  logic [10:0] LEFT_L, LEFT_R, RIGHT_L, RIGHT_R;
  logic        MOVING, DIR, FRAME;

  int n_total = 0;
  int n_pass  = 0;

  square_motion_ctrl dut (
    .CLK      (CLK),
    .rst      (rst),
    .VS       (VS),
    .KEY_MOVE (KEY_MOVE),
    .MODE     (MODE),
    .SPEED    (SPEED),
    .LEFT_L   (LEFT_L),
    .LEFT_R   (LEFT_R),
    .RIGHT_L  (RIGHT_L),
    .RIGHT_R  (RIGHT_R),
    .MOVING   (MOVING),
    .DIR      (DIR),
    .FRAME    (FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        key;
    logic        mode;
    logic [2:0]  speed;
    logic [10:0] exp_x;
    logic        exp_moving;
    logic        exp_dir;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_pos(input string name, input int x, input logic dir, input logic mv);
    check({name, " LEFT_L"},  32'(LEFT_L),  32'(x));
    check({name, " LEFT_R"},  32'(LEFT_R),  32'(x + 64));
    check({name, " RIGHT_L"}, 32'(RIGHT_L), 32'(x + 128));
    check({name, " RIGHT_R"}, 32'(RIGHT_R), 32'(x + 192));
    check({name, " DIR"},     32'(DIR),     32'(dir));
    check({name, " MOVING"},  32'(MOVING),  32'(mv));
  endtask

  // One frame of 8 CLKs: VS low for 4, high for 4. Outputs settle before return.
  task automatic tick(input logic key, input logic mode, input logic [2:0] spd);
    KEY_MOVE = key;
    MODE     = mode;
    SPEED    = spd;
    VS       = 1'b0;
    repeat (4) @(negedge CLK);
    VS = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic ticks(input int n, input logic key, input logic mode, input logic [2:0] spd);
    for (int i = 0; i < n; i++) tick(key, mode, spd);
  endtask

  initial begin
    // Debounce, step and release table, one row per frame, starting from home.
    vecs[0] = '{1'b1, 1'b0, 3'd2, 11'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 3'd2, 11'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 3'd2, 11'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 3'd2, 11'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 3'd2, 11'd2, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 3'd2, 11'd4, 1'b1, 1'b0};
    for (int i = 6; i < 16; i++)
      vecs[i] = '{1'b0, 1'b0, 3'd0, 11'(5 + i - 6), 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 3'd1, 11'd15, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'd1, 11'd16, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 3'd1, 11'd17, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 3'd1, 11'd17, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 3'd1, 11'd17, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 3'd1, 11'd17, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 3'd1, 11'd17, 1'b0, 1'b0};

    rst = 1'b0; VS = 1'b1; KEY_MOVE = 1'b1; MODE = 1'b0; SPEED = 3'd2;
    repeat (3) @(negedge CLK);
    check_pos("reset", 0, 1'b0, 1'b0);
    check("reset FRAME", 32'(FRAME), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge CLK);

    // FRAME latency: high exactly on the 3rd CLK after VS falls, for one CLK.
    VS = 1'b0;
    repeat (2) @(negedge CLK);
    check("frame lat2", 32'(FRAME), 32'd0);
    @(negedge CLK);
    check("frame lat3", 32'(FRAME), 32'd1);
    @(negedge CLK);
    check("frame lat4", 32'(FRAME), 32'd0);
    VS = 1'b1;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < 23; i++) begin
      tick(vecs[i].key, vecs[i].mode, vecs[i].speed);
      check($sformatf("vec%0d x", i),      32'(LEFT_L),  32'(vecs[i].exp_x));
      check($sformatf("vec%0d rr", i),     32'(RIGHT_R), 32'(vecs[i].exp_x) + 32'd192);
      check($sformatf("vec%0d moving", i), 32'(MOVING),  32'(vecs[i].exp_moving));
      check($sformatf("vec%0d dir", i),    32'(DIR),     32'(vecs[i].exp_dir));
    end

    // Fresh start from home, debounce, then climb to 447 and wrap.
    @(negedge CLK); #2 rst = 1'b0;
    @(negedge CLK); rst = 1'b1;
    check_pos("home2", 0, 1'b0, 1'b0);
    ticks(3, 1'b0, 1'b0, 3'd7);
    check_pos("run2", 0, 1'b0, 1'b1);
    ticks(63, 1'b0, 1'b0, 3'd7);
    check_pos("climb441", 441, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 3'd6);
    check_pos("climb447", 447, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 3'd2);
    check_pos("wrap", 0, 1'b0, 1'b1);

    // Climb again, bounce at the right edge.
    ticks(63, 1'b0, 1'b0, 3'd7);
    tick(1'b0, 1'b0, 3'd6);
    check_pos("climb447b", 447, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("bounce448", 448, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("back444", 444, 1'b1, 1'b1);

    // Mid-frame changes and a missing VS leave everything frozen.
    begin
      int pulses = 0;
      SPEED = 3'd7; MODE = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge CLK);
        if (FRAME) pulses++;
      end
      check("no vs pulses", 32'(pulses), 32'd0);
      check_pos("frozen", 444, 1'b1, 1'b1);
    end

    // Switching to wrap mode while moving left turns round without moving.
    tick(1'b0, 1'b0, 3'd4);
    check_pos("mode turn", 444, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("exact max", 448, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("over max", 448, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("left444", 444, 1'b1, 1'b1);
    ticks(63, 1'b0, 1'b1, 3'd7);
    check_pos("desc3", 3, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 3'd1);
    check_pos("desc2", 2, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("left edge", 0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("right again", 4, 1'b0, 1'b1);

    // Asynchronous reset mid-run: home immediately, then re-debounce.
    @(negedge CLK); #2 rst = 1'b0;
    #1;
    check_pos("async rst", 0, 1'b0, 1'b0);
    @(negedge CLK); rst = 1'b1;
    tick(1'b0, 1'b1, 3'd4);
    check_pos("rdeb1", 0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("rdeb2", 0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("rdeb3", 0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 3'd4);
    check_pos("rdeb4", 4, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
